// File: rtl/ext_uart_rx.sv
// ext_uart_rx: 8N1 serial receiver feeding a small byte FIFO that is read by
// the core through a ready/acknowledge handshake (cd/crda/cack).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rxd          serial line, idle high, asynchronous to clk
//   cd[7:0]      head-of-FIFO byte, valid while crda=1
//   crda         FIFO non-empty
//   cack         pop request, honoured only while crda=1
//   count        FIFO occupancy (DEPTH_LOG2+1 bits)
//   err_frame    one-cycle pulse: stop bit sampled low, byte discarded
//   err_overrun  one-cycle pulse: good byte dropped because the FIFO was full
//
// Parameters:
//   CLK_DIV      clock cycles per serial bit (>= 4)
//   DEPTH_LOG2   log2 of FIFO depth (>= 1)
module ext_uart_rx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    output logic [7:0]            cd,
    output logic                  crda,
    input  logic                  cack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  err_frame,
    output logic                  err_overrun
);

    localparam int unsigned CW    = $clog2(CLK_DIV);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2;

    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] FULL_XOR    = PW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]                 sync_q,  sync_d;
    logic [1:0]                 prime_q, prime_d;
    logic                       armed_q, armed_d;
    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q,   cnt_d;
    logic [2:0]                 idx_q,   idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic [DEPTH-1:0][7:0]      mem_q,   mem_d;
    logic [PW-1:0]              wr_q,    wr_d;
    logic [PW-1:0]              rd_q,    rd_d;
    logic [7:0]                 cd_q,    cd_d;
    logic                       crda_q,  crda_d;
    logic [PW-1:0]              count_q, count_d;
    logic                       err_frame_q,   err_frame_d;
    logic                       err_overrun_q, err_overrun_d;

    // Combinational helpers
    logic rxs;
    logic cnt_zero;
    logic byte_done;
    logic frame_err;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic overrun;

    assign rxs = sync_q[1];

    // Two-flop synchroniser and start-detect arming. The synchroniser resets
    // to 1, so its reset value must be flushed before a high line can be
    // trusted; prime_q counts those two cycles.
    always_comb begin
        sync_d  = {sync_q[0], rxd};
        prime_d = {prime_q[0], 1'b1};
        armed_d = armed_q | (prime_q[1] & rxs);
    end

    // Receive FSM: next state, bit timing and data shift.
    always_comb begin
        cnt_zero  = (cnt_q == '0);
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = BIT_RELOAD;
                        idx_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = BIT_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    // Return to IDLE in the same cycle so back-to-back frames
                    // can re-arm on the very next low sample.
                    state_d = S_IDLE;
                    if (rxs) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. A pop in the same cycle frees the slot for a push
    // even when full; the registered head byte and flags track next state.
    always_comb begin
        fifo_empty    = (wr_q == rd_q);
        fifo_full     = ((wr_q ^ rd_q) == FULL_XOR);
        pop           = cack & ~fifo_empty;
        push          = byte_done & (~fifo_full | pop);
        overrun       = byte_done & fifo_full & ~pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = shift_q;
        end
        wr_d          = wr_q + PW'(push);
        rd_d          = rd_q + PW'(pop);
        cd_d          = mem_d[rd_d[AW-1:0]];
        crda_d        = (wr_d != rd_d);
        count_d       = wr_d - rd_d;
        err_frame_d   = frame_err;
        err_overrun_d = overrun;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= 2'b11;
            prime_q       <= 2'b00;
            armed_q       <= 1'b0;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            mem_q         <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            cd_q          <= 8'h00;
            crda_q        <= 1'b0;
            count_q       <= '0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prime_q       <= prime_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            mem_q         <= mem_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cd_q          <= cd_d;
            crda_q        <= crda_d;
            count_q       <= count_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign cd          = cd_q;
    assign crda        = crda_q;
    assign count       = count_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ext_uart_rx.sv
// tb_ext_uart_rx: directed bench for ext_uart_rx with CLK_DIV=16, DEPTH_LOG2=2.
module tb_ext_uart_rx;

    localparam int unsigned CLK_DIV    = 16;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned FRAME_CYC  = 10 * CLK_DIV;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rxd;
    logic                 cack;
    logic [7:0]           cd;
    logic                 crda;
    logic [DEPTH_LOG2:0]  count;
    logic                 err_frame;
    logic                 err_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters observed on the falling edge
    int         n_ferr    = 0;
    int         n_ovr     = 0;
    int         n_rise    = 0;
    int         n_high    = 0;
    logic [7:0] last_cd   = 8'h00;
    logic       crda_prev = 1'b0;

    int base_a;
    int base_b;

    ext_uart_rx #(
        .CLK_DIV    (CLK_DIV),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .cd          (cd),
        .crda        (crda),
        .cack        (cack),
        .count       (count),
        .err_frame   (err_frame),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_frame)   n_ferr <= n_ferr + 1;
        if (err_overrun) n_ovr  <= n_ovr + 1;
        if (crda && !crda_prev) n_rise <= n_rise + 1;
        if (crda) begin
            n_high  <= n_high + 1;
            last_cd <= cd;
        end
        crda_prev <= crda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; each bit lasts CLK_DIV cycles. With pop_at_stop,
    // cack is high exactly at the edge where the receiver samples the stop bit
    // (2 sync + 1 detect + 8 half-bit + 9*16 bit cycles = edge 155).
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input logic pop_at_stop);
        logic [9:0] bits;
        bits = {stop_lvl, data, 1'b0};
        @(posedge clk);
        #1;
        rxd = bits[0];
        for (int k = 1; k < int'(FRAME_CYC); k++) begin
            @(posedge clk);
            #1;
            rxd = bits[k / int'(CLK_DIV)];
            if (pop_at_stop) begin
                if (k == 154) cack = 1'b1;
                else if (k == 155) cack = 1'b0;
            end
        end
    endtask

    task automatic pop_expect(input logic [7:0] expv, input string tag);
        sample();
        check({tag, "_crda"}, 32'(crda), 32'd1);
        check({tag, "_cd"},   32'(cd),   32'(expv));
        @(posedge clk);
        #1;
        cack = 1'b1;
        @(posedge clk);
        #1;
        cack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rxd   = 1'b1;
        cack  = 1'b0;
        tick(3);

        // Reset state
        sample();
        check("rst_crda",  32'(crda),        32'd0);
        check("rst_count", 32'(count),       32'd0);
        check("rst_cd",    32'(cd),          32'h00);
        check("rst_ferr",  32'(err_frame),   32'd0);
        check("rst_ovr",   32'(err_overrun), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(10);

        // Single byte 0x5A
        base_a = n_rise;
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(4);
        sample();
        check("t1_count", 32'(count),           32'd1);
        check("t1_rise",  32'(n_rise - base_a), 32'd1);
        pop_expect(8'h5A, "t1_pop");
        sample();
        check("t1_crda_after", 32'(crda),  32'd0);
        check("t1_count_after", 32'(count), 32'd0);
        check("t1_rise_once", 32'(n_rise - base_a), 32'd1);

        // Five back-to-back bytes into a 4-deep FIFO
        base_a = n_ovr;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b0);
        tick(4);
        sample();
        check("t2_count", 32'(count),          32'd4);
        check("t2_ovr",   32'(n_ovr - base_a), 32'd1);
        pop_expect(8'h01, "t2_pop1");
        pop_expect(8'h02, "t2_pop2");
        pop_expect(8'h03, "t2_pop3");
        pop_expect(8'h04, "t2_pop4");
        sample();
        check("t2_crda_empty", 32'(crda),  32'd0);
        check("t2_count_empty", 32'(count), 32'd0);

        // Full FIFO with a pop coinciding with the stop sample
        base_a = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h13, 1'b1, 1'b0);
        send_frame(8'h14, 1'b1, 1'b0);
        sample();
        check("t3_count_full", 32'(count), 32'd4);
        send_frame(8'h15, 1'b1, 1'b1);
        tick(4);
        sample();
        check("t3_count", 32'(count),          32'd4);
        check("t3_ovr",   32'(n_ovr - base_a), 32'd0);
        pop_expect(8'h12, "t3_pop1");
        pop_expect(8'h13, "t3_pop2");
        pop_expect(8'h14, "t3_pop3");
        pop_expect(8'h15, "t3_pop4");
        sample();
        check("t3_crda_empty", 32'(crda), 32'd0);

        // Framing error, then a good byte
        base_a = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b0);
        rxd = 1'b1;
        tick(40);
        sample();
        check("t4_ferr",  32'(n_ferr - base_a), 32'd1);
        check("t4_count", 32'(count),           32'd0);
        check("t4_crda",  32'(crda),            32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(4);
        sample();
        check("t4_count_good", 32'(count), 32'd1);
        pop_expect(8'h3C, "t4_pop");
        sample();
        check("t4_ferr_once", 32'(n_ferr - base_a), 32'd1);

        // Short glitch while idle
        base_a = n_ferr;
        base_b = n_rise;
        @(posedge clk);
        #1;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(60);
        sample();
        check("t5_glitch_count", 32'(count),           32'd0);
        check("t5_glitch_rise",  32'(n_rise - base_b), 32'd0);
        check("t5_glitch_ferr",  32'(n_ferr - base_a), 32'd0);

        // Reset in the middle of a frame, line held low across release
        @(posedge clk);
        #1;
        rxd = 1'b0;
        tick(60);
        reset = 1'b0;
        sample();
        check("t5_rst_crda",  32'(crda),  32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(30);
        rxd = 1'b1;
        tick(250);
        sample();
        check("t5_abort_crda",  32'(crda),            32'd0);
        check("t5_abort_count", 32'(count),           32'd0);
        check("t5_abort_rise",  32'(n_rise - base_b), 32'd0);
        check("t5_abort_ferr",  32'(n_ferr - base_a), 32'd0);

        // cack held high while empty, then one byte
        cack   = 1'b1;
        tick(5);
        base_a = n_high;
        send_frame(8'h77, 1'b1, 1'b0);
        tick(10);
        sample();
        check("t6_high_cycles", 32'(n_high - base_a), 32'd1);
        check("t6_cd_seen",     32'(last_cd),         32'h77);
        check("t6_count",       32'(count),           32'd0);
        check("t6_crda",        32'(crda),            32'd0);
        cack = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
